// File: rtl/rr_shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM state encodings and default sizing.
package rr_shared_reg_arbiter_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StAck   = 2'd2;

    localparam int unsigned DefNReq  = 4;
    localparam int unsigned DefDataW = 8;

endpackage

// File: rtl/rr_shared_reg_arbiter_rr_pick.sv
// Combinational round-robin priority selector: the first set request found
// scanning last+1, last+2, ... (mod N_REQ) wins.
module rr_shared_reg_arbiter_rr_pick
    import rr_shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] winner_oh,
    output logic [ID_W-1:0]  winner_idx,
    output logic             valid
);

    // Scan from the position after the previous winner; the first hit wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand       = '0;
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid           = 1'b1;
                winner_oh[cand] = 1'b1;
                winner_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared DATA_W-bit register.
// IDLE arbitrates, GRANT commits the winner's data (or aborts if its request
// was withdrawn), ACK emits a one-cycle acknowledge.
module rr_shared_reg_arbiter
    import rr_shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = DefNReq,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [ID_W-1:0]         owner,
    output logic                    busy,
    output logic [DATA_W-1:0]       q
);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]  gnt_d, ack_d;
    logic [ID_W-1:0]   owner_d;
    logic [DATA_W-1:0] q_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;

    rr_shared_reg_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req),
        .last       (last_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    // Next-state logic; the pointer only moves on a committed write.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        gnt_d   = gnt;
        ack_d   = '0;
        owner_d = owner;
        q_d     = q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick_oh;
                    win_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt_d   = '0;
                state_d = StIdle;
                if (req[win_q]) begin
                    q_d     = din[win_q*DATA_W +: DATA_W];
                    owner_d = win_q;
                    last_d  = win_q;
                    ack_d   = gnt;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State, pointer and shared register; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= ID_W'(N_REQ - 1);
            win_q   <= '0;
            gnt     <= '0;
            ack     <= '0;
            owner   <= '0;
            q       <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            gnt     <= gnt_d;
            ack     <= ack_d;
            owner   <= owner_d;
            q       <= q_d;
        end
    end

    // Busy whenever a transaction is in flight.
    always_comb begin
        busy = (state_q != StIdle);
    end

endmodule
